uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

UART serial transmitter: the transmit half of the UART link. It accepts a byte on a single-cycle start strobe and shifts out one asynchronous frame on `tx`: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing uses the same 16x-oversampled baud tick the receive path uses, so each bit lasts exactly 16 tick pulses. The block sits between the host-side byte source and the serial pin.

## Interface
- `PARITY_EN`, default 0: 1 inserts a parity bit after D7.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 and 2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  single-`clk` enable pulse at 16x the baud rate.
- `tx_start`  in  1  request to send `tx_data`; sampled only when `tx_busy`=0.
- `tx_data`  in  8  byte to send; captured on the accepting edge.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high from the accepting edge until the frame completes.
- `tx_done`  out  1  one-`clk` pulse on frame completion.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, tick counter 0, bit index 0, shift register 0x00.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `tx_start`=1, latch `tx_data` into the shift register. If `PARITY_EN`=1, latch the parity bit as the XOR of the data, inverted when `PARITY_ODD`=1. Clear the tick counter, set `tx_busy`=1, and go to START.
- START: `tx`=0.
- DATA: `tx` = shift-register bit 0, which puts D0 on the line first.
- PARITY: `tx` = latched parity bit.
- STOP: `tx`=1.
- 4-bit tick counter, active in every non-IDLE state:
  - Each `baud_tick` increments it, wrapping from 15 to 0.
  - The tick that wraps it (count==15 with `baud_tick`=1) ends the current bit.
- Transitions at end of bit:
  - START -> DATA.
  - DATA: shift right and increment the 3-bit bit index. After bit index 7, go to PARITY if `PARITY_EN`=1, else STOP. Bit index returns to 0.
  - PARITY -> STOP.
  - STOP: repeat once if `STOP_BITS`=2. After the last stop bit, go to IDLE, `tx_busy`=0, `tx_done`=1 for one cycle.
- `tx_start` while `tx_busy`=1 is ignored. No queuing; `tx_data` changes mid-frame have no effect.
- `baud_tick` in IDLE is ignored. The counter does not run.
- Reset asserted mid-frame: outputs return to reset values immediately, without waiting for a clock edge. The partial frame is abandoned; no `tx_done`.

## Timing
- Acceptance edge N (IDLE, `tx_start`=1): `tx`=0 and `tx_busy`=1 are visible after edge N.
- Each bit spans exactly 16 `baud_tick` pulses, counted from the first tick after entering the state.
- The start bit is not tick-aligned: it lasts 16 ticks plus 0 to 1 tick period, depending on where acceptance falls relative to the tick.
- Frame length in ticks = 16 x (1 + 8 + `PARITY_EN` + `STOP_BITS`): 160 for 8N1, 192 for 8E2.
- `tx_done` and `tx_busy` falling occur on the same edge, the edge that samples the final wrapping tick. `tx` is 1 on that edge and stays 1.
- Back-to-back frames: `tx_start` held high or asserted on the cycle after `tx_done` is accepted on that next edge. Minimum gap is 1 `clk` of idle-high line.
- `tx_start` coinciding with the `tx_done` edge is not accepted, because `tx_busy` is still 1 when it is sampled.
- All outputs are registered.

## Test plan
- Reset, then idle: `tx`=1, `tx_busy`=0, `tx_done`=0. Pulse `baud_tick` with no start; outputs unchanged.
- 8N1, `baud_tick` every 4 clocks, send 0xA5:
  - `tx` sequence per 16 ticks is 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses once, 160 ticks after acceptance.
  - `tx_busy` high for exactly that span.
- `PARITY_EN`=1:
  - `PARITY_ODD`=0, send 0x07: parity bit = 1.
  - `PARITY_ODD`=1, send 0x07: parity bit = 0.
  - `PARITY_ODD`=1, send 0x00: parity bit = 1.
  - `STOP_BITS`=2: line high for 32 ticks before `tx_done`.
- Mid-frame disturbances:
  - Assert `tx_start` with 0xFF during the DATA state of a 0x00 frame: ignored, 0x00 frame completes unchanged.
  - Change `tx_data` mid-frame: no effect on the bits sent.
- Back-to-back: hold `tx_start`=1 with 0x55 then 0x3C. Two complete frames, exactly 1 idle-high `clk` between them, two `tx_done` pulses.
- Assert `rst` asynchronously during bit D3 (between clock edges):
  - `tx`=1 and `tx_busy`=0 before the next clock edge, with no `tx_done`.
  - A following send of 0x81 is framed correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: tx drops to the start bit on the accepting edge; each bit lasts 16 baud_tick pulses.
// Backpressure: tx_start is ignored while tx_busy=1; there is no queuing.
module uart_tx_frame #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       parity_bit;
  logic       stop_idx;
  logic       end_bit;

  // A bit ends on the tick that wraps the counter from 15 back to 0.
  assign end_bit = (state != IDLE) && baud_tick && (tick_cnt == 4'd15);

  // Frame sequencer; tx is registered, so each transition loads the next bit's level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      parity_bit <= 1'b0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE && baud_tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shreg      <= tx_data;
            parity_bit <= (PARITY_EN != 0) ? ((^tx_data) ^ (PARITY_ODD != 0)) : 1'b0;
            tick_cnt   <= 4'd0;
            bit_idx    <= 3'd0;
            stop_idx   <= 1'b0;
            tx_busy    <= 1'b1;
            tx         <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (end_bit) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (end_bit) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (end_bit) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (end_bit) begin
            if (STOP_BITS == 2 && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 8E2, 8O1) share clock, reset and tick.
// Frames are sampled mid-bit by counting baud ticks since acceptance.
// Includes mid-frame disturbances, back-to-back frames and an asynchronous mid-frame reset.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [2:0] start_r = 3'b000;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  int total = 0;
  int bad = 0;
  int tick_total = 0;

  uart_tx_frame #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_r[0]), .tx_data(tx_data),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_r[1]), .tx_data(tx_data),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_r[2]), .tx_data(tx_data),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  always #5 clk = ~clk;

  // baud_tick high for one clk in every four, changed on falling edges
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = div + 1;
      baud_tick = ((div % 4) == 0);
    end
  end

  always @(posedge clk) begin
    if (baud_tick) tick_total <= tick_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input int inst, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    start_r[inst] = 1'b1;
    @(negedge clk);
  endtask

  // Called on the falling edge just after the accepting edge; returns on the tx_done edge.
  task automatic monitor_frame(input int inst, input int nbits, input logic [11:0] bits,
                               input bit keep, input int dist_t, input logic [7:0] dist_data,
                               input bit dist_pulse, input string name);
    int t0, t, k, cyc;
    bit seen_done, busy_ok, pulsing, dist_done;
    if (!keep) start_r[inst] = 1'b0;
    chk({name, "_accept_tx"}, {31'd0, tx_w[inst]}, 32'd0);
    chk({name, "_accept_busy"}, {31'd0, busy_w[inst]}, 32'd1);
    chk({name, "_accept_done"}, {31'd0, done_w[inst]}, 32'd0);
    t0 = tick_total; k = 0; cyc = 0;
    seen_done = 0; busy_ok = 1; pulsing = 0; dist_done = 0;
    while (!seen_done && cyc < nbits * 64 + 40) begin
      @(negedge clk);
      cyc++;
      if (pulsing) begin
        start_r[inst] = 1'b0;
        pulsing = 0;
      end
      t = tick_total - t0;
      if (done_w[inst]) begin
        seen_done = 1;
        chk({name, "_done_tick"}, t, 16 * nbits);
        chk({name, "_done_busy"}, {31'd0, busy_w[inst]}, 32'd0);
        chk({name, "_done_tx"}, {31'd0, tx_w[inst]}, 32'd1);
      end else begin
        if (!busy_w[inst]) busy_ok = 0;
        if (k < nbits && t == 16 * k + 8) begin
          chk($sformatf("%s_bit%0d", name, k), {31'd0, tx_w[inst]}, {31'd0, bits[k]});
          k++;
        end
        if (dist_t >= 0 && t == dist_t && !dist_done) begin
          tx_data = dist_data;
          if (dist_pulse) begin
            start_r[inst] = 1'b1;
            pulsing = 1;
          end
          dist_done = 1;
        end
      end
    end
    chk({name, "_done_seen"}, {31'd0, seen_done}, 32'd1);
    chk({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    chk({name, "_bits_sampled"}, k, nbits);
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] bits;     // bit k = line level during frame bit k (start bit is bit 0)
    int          dist_t;
    logic [7:0]  dist_data;
    bit          dist_pulse;
    string       name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, cyc;
    bit reached, done_flag;

    // 0xA5 8N1: line 0,1,0,1,0,0,1,0,1,1
    vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, -1, 8'h00, 1'b0, "a5_8n1"};
    // 0x07 even parity, 2 stop: three ones -> parity 1
    vecs[1] = '{1, 8'h07, 12, {2'b11, 1'b1, 8'h07, 1'b0}, -1, 8'h00, 1'b0, "07_8e2"};
    // 0x07 odd parity -> parity 0
    vecs[2] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, -1, 8'h00, 1'b0, "07_8o1"};
    // 0x00 odd parity -> parity 1
    vecs[3] = '{2, 8'h00, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, -1, 8'h00, 1'b0, "00_8o1"};
    // 0x00 with a 0xFF start request during D1: ignored
    vecs[4] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}, 40, 8'hFF, 1'b1, "00_start_ignored"};
    // 0x3C (four ones -> even parity 0) with tx_data changed during D3
    vecs[5] = '{1, 8'h3C, 12, {2'b11, 1'b0, 8'h3C, 1'b0}, 70, 8'hC3, 1'b0, "3c_data_change"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_tx%0d", i), {31'd0, tx_w[i]}, 32'd1);
      chk($sformatf("reset_busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
      chk($sformatf("reset_done%0d", i), {31'd0, done_w[i]}, 32'd0);
    end
    // ticks keep arriving; idle outputs must not move
    repeat (20) @(negedge clk);
    chk("idle_ticks_tx", {29'd0, tx_w}, 32'h7);
    chk("idle_ticks_busy", {29'd0, busy_w}, 32'h0);
    chk("idle_ticks_done", {29'd0, done_w}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].inst, vecs[i].data);
      monitor_frame(vecs[i].inst, vecs[i].nbits, vecs[i].bits, 1'b0, vecs[i].dist_t,
                    vecs[i].dist_data, vecs[i].dist_pulse, vecs[i].name);
      @(negedge clk);
      chk({vecs[i].name, "_done_single"}, {31'd0, done_w[vecs[i].inst]}, 32'd0);
      chk({vecs[i].name, "_idle_tx"}, {31'd0, tx_w[vecs[i].inst]}, 32'd1);
    end

    // back-to-back: tx_start held; second byte loaded while the first frame is in flight
    start_frame(0, 8'h55);
    monitor_frame(0, 10, {2'b00, 1'b1, 8'h55, 1'b0}, 1'b1, 20, 8'h3C, 1'b0, "b2b_55");
    @(negedge clk);
    monitor_frame(0, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, 1'b0, -1, 8'h00, 1'b0, "b2b_3c");
    @(negedge clk);
    chk("b2b_done_single", {31'd0, done_w[0]}, 32'd0);

    // asynchronous reset during D3 (frame bit 4)
    start_frame(0, 8'h5A);
    start_r[0] = 1'b0;
    t0 = tick_total;
    reached = 0;
    cyc = 0;
    while (!reached && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (tick_total - t0 == 72) reached = 1;
    end
    chk("rst_reached_d3", {31'd0, reached}, 32'd1);
    chk("rst_pre_busy", {31'd0, busy_w[0]}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("rst_async_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("rst_async_done", {31'd0, done_w[0]}, 32'd0);
    done_flag = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0]) done_flag = 1;
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (done_w[0]) done_flag = 1;
    end
    chk("rst_no_done", {31'd0, done_flag}, 32'd0);
    chk("rst_idle_tx", {31'd0, tx_w[0]}, 32'd1);

    start_frame(0, 8'h81);
    monitor_frame(0, 10, {2'b00, 1'b1, 8'h81, 1'b0}, 1'b0, -1, 8'h00, 1'b0, "81_after_rst");
    @(negedge clk);
    chk("81_done_single", {31'd0, done_w[0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
